// File: rtl/scanner_link_pkg.sv
// Shared encodings for the station/scanner link: command and status codes
// carried on the 2-bit buses, and the transmitter FSM state type.
package scanner_link_pkg;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_SCAN  = 2'b01;
    localparam logic [1:0] CMD_XFER  = 2'b10;
    localparam logic [1:0] CMD_FLUSH = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SCAN  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [1:0] ST_XFER  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        XFER = 2'd2
    } state_e;

endpackage

// File: rtl/scanner_link_tx_if.sv
// Station/scanner link bundle: command/scan inputs toward the scanner and
// status/serial outputs back toward the station.
interface scanner_link_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic [1:0]        cmd_in;
    logic              scan_valid;
    logic [DATA_W-1:0] scan_data;
    logic              station_ready;
    logic [1:0]        status_out;
    logic              ser_data;
    logic              ser_valid;
    logic              ser_last;
    logic [FILL_W-1:0] fill;
    logic              overflow;

    modport master (
        output cmd_in, scan_valid, scan_data, station_ready,
        input  status_out, ser_data, ser_valid, ser_last, fill, overflow
    );

    modport slave (
        input  cmd_in, scan_valid, scan_data, station_ready,
        output status_out, ser_data, ser_valid, ser_last, fill, overflow
    );

endinterface

// File: rtl/scanner_link_tx_fifo.sv
// Synchronous first-word-fall-through FIFO holding scanned words until the
// station pulls them; a write while full is accepted only alongside a read.
module scan_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_i,
    input  logic                       rd_i,
    input  logic                       flush_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     fill_o
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0] fill_q;
    logic              rd_ok_d, wr_ok_d;

    assign full_o    = (fill_q == FILL_W'(DEPTH));
    assign empty_o   = (fill_q == '0);
    assign fill_o    = fill_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign rd_ok_d = rd_i && !empty_o;
    assign wr_ok_d = wr_i && (!full_o || rd_ok_d);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (wr_ok_d) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok_d) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_ok_d && !rd_ok_d)      fill_q <= fill_q + 1'b1;
            else if (rd_ok_d && !wr_ok_d) fill_q <= fill_q - 1'b1;
        end
    end

    // Storage carries no reset; only pointers and occupancy are control.
    always_ff @(posedge clk_i) begin
        if (wr_ok_d) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/scanner_link_tx.sv
// Scanner-side link transmitter: buffers scanned words, reports status and
// serializes words MSB-first toward the station when asked to transfer.
module scanner_link_tx
    import scanner_link_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int READY_LVL = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    scanner_link_if.slave link
);
    localparam int FILL_W = $clog2(DEPTH) + 1;
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              load_q;
    logic              ser_data_q, ser_valid_q, ser_last_q, overflow_q;

    logic              fifo_full, fifo_empty;
    logic [FILL_W-1:0] fifo_fill;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              active_d, flush_d, rd_d, wr_req_d, wr_d, ovf_set_d, last_bit_d;
    logic [1:0]        status_d;

    assign active_d   = (state_q == SCAN) || (state_q == XFER);
    assign flush_d    = active_d && (link.cmd_in == CMD_FLUSH);
    assign rd_d       = (state_q == XFER) && load_q && !flush_d;
    assign wr_req_d   = active_d && link.scan_valid && !flush_d;
    assign wr_d       = wr_req_d && (!fifo_full || rd_d);
    assign ovf_set_d  = wr_req_d && fifo_full && !rd_d;
    assign last_bit_d = (bit_cnt_q == CNT_W'(DATA_W - 1));

    scan_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_i      (wr_d),
        .rd_i      (rd_d),
        .flush_i   (flush_d),
        .wr_data_i (link.scan_data),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .fill_o    (fifo_fill)
    );

    always_comb begin
        status_d = ST_IDLE;
        case (state_q)
            SCAN:    status_d = (fifo_fill >= FILL_W'(READY_LVL)) ? ST_READY : ST_SCAN;
            XFER:    status_d = ST_XFER;
            default: status_d = ST_IDLE;
        endcase
    end

    assign link.status_out = status_d;
    assign link.ser_data   = ser_data_q;
    assign link.ser_valid  = ser_valid_q;
    assign link.ser_last   = ser_last_q;
    assign link.fill       = fifo_fill;
    assign link.overflow   = overflow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            load_q      <= 1'b0;
            bit_cnt_q   <= '0;
            ser_data_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            ser_data_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            if (ovf_set_d) overflow_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (link.cmd_in == CMD_SCAN) state_q <= SCAN;
                end
                SCAN: begin
                    if (link.cmd_in == CMD_FLUSH) begin
                        state_q    <= IDLE;
                        overflow_q <= 1'b0;
                    end else if (link.cmd_in == CMD_XFER && !fifo_empty) begin
                        state_q <= XFER;
                        load_q  <= 1'b1;
                    end
                end
                XFER: begin
                    if (link.cmd_in == CMD_FLUSH) begin
                        state_q    <= IDLE;
                        load_q     <= 1'b0;
                        overflow_q <= 1'b0;
                    end else if (load_q) begin
                        shift_q   <= fifo_rd_data;
                        bit_cnt_q <= '0;
                        load_q    <= 1'b0;
                    end else if (link.station_ready) begin
                        ser_valid_q <= 1'b1;
                        ser_data_q  <= shift_q[DATA_W-1];
                        ser_last_q  <= last_bit_d;
                        shift_q     <= shift_q << 1;
                        bit_cnt_q   <= bit_cnt_q + 1'b1;
                        // Word done: reload costs one idle cycle, or fall back to scanning.
                        if (last_bit_d) begin
                            if (!fifo_empty) load_q  <= 1'b1;
                            else             state_q <= SCAN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
